// File: rtl/luna_pkg.sv
// Shared constants, packer state encoding and the reference quantizer for the
// layer-0 input path. The quantize() function is the same arithmetic as the
// layer0_quantizer module and is kept here so software models can reuse it.
package luna_pkg;

  localparam int FEAT_W   = 16;
  localparam int NUM_FEAT = 32;
  localparam int QB       = 2;
  localparam int OUT_W    = NUM_FEAT * QB;
  localparam int SHIFT    = 8;
  localparam int OFFSET   = 2;

  typedef enum logic {
    FILL    = 1'b0,
    DISCARD = 1'b1
  } state_t;

  // clamp((sample >>> SHIFT) + OFFSET, 0, 2**QB-1), computed one bit wider
  // than the sample so the offset add can never wrap.
  function automatic logic [QB-1:0] quantize(input logic signed [FEAT_W-1:0] sample);
    logic signed [FEAT_W:0] v;
    v = $signed({sample[FEAT_W-1], sample});
    v = v >>> SHIFT;
    v = v + (FEAT_W+1)'(OFFSET);
    if (v < 0)
      return '0;
    else if (v > (FEAT_W+1)'((1 << QB) - 1))
      return QB'((1 << QB) - 1);
    else
      return v[QB-1:0];
  endfunction

endpackage

// File: rtl/layer0_quantizer.sv
// Combinational feature quantizer: arithmetic shift, signed offset, clamp to
// an unsigned QB-bit code.
// Ports:
//   sample  in  FEAT_W  signed feature sample
//   code    out QB      quantized code in [0, 2**QB-1]
module layer0_quantizer #(
  parameter int FEAT_W = 16,
  parameter int QB     = 2,
  parameter int SHIFT  = 8,
  parameter int OFFSET = 2
) (
  input  logic signed [FEAT_W-1:0] sample,
  output logic        [QB-1:0]     code
);

  localparam logic signed [FEAT_W:0] OFF_S = (FEAT_W+1)'(OFFSET);
  localparam logic signed [FEAT_W:0] MAX_S = (FEAT_W+1)'((1 << QB) - 1);

  logic signed [FEAT_W:0] ext;
  logic signed [FEAT_W:0] sum;

  // One extra bit of headroom keeps the offset add from wrapping at the rails.
  always_comb begin
    ext = $signed({sample[FEAT_W-1], sample});
    sum = (ext >>> SHIFT) + OFF_S;
    if (sum < 0)
      code = '0;
    else if (sum > MAX_S)
      code = MAX_S[QB-1:0];
    else
      code = sum[QB-1:0];
  end

endmodule

// File: rtl/layer0_input_packer.sv
// Packs a frame of NUM_FEAT quantized feature samples into one flat vector
// for the layer-0 neuron LUTs and presents it on a registered valid/ready
// output. Frames of the wrong length raise a one-cycle len_err pulse.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready       input sample handshake
//   s_data, s_last        signed sample, end-of-frame marker
//   m_valid/m_ready       packed vector handshake
//   m_data                packed codes, feature i at [i*QB +: QB]
//   len_err               frame length mismatch pulse
module layer0_input_packer #(
  parameter int FEAT_W   = luna_pkg::FEAT_W,
  parameter int NUM_FEAT = luna_pkg::NUM_FEAT,
  parameter int QB       = luna_pkg::QB,
  parameter int SHIFT    = luna_pkg::SHIFT,
  parameter int OFFSET   = luna_pkg::OFFSET,
  parameter int OUT_W    = NUM_FEAT * QB
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [FEAT_W-1:0] s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic        [OUT_W-1:0]  m_data,
  output logic                     len_err
);

  import luna_pkg::*;

  localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [OUT_W-1:0]  acc;
  logic [OUT_W-1:0]  acc_ins;
  logic              acc_full;
  logic [QB-1:0]     q;
  logic              accept;
  logic              out_free;
  logic              frame_done;
  logic              frame_short;

  layer0_quantizer #(
    .FEAT_W (FEAT_W),
    .QB     (QB),
    .SHIFT  (SHIFT),
    .OFFSET (OFFSET)
  ) u_quant (
    .sample (s_data),
    .code   (q)
  );

  assign s_ready  = (state == DISCARD) || !acc_full;
  assign accept   = s_valid && s_ready;
  // The output register can take a new frame when empty or draining this cycle.
  assign out_free = !m_valid || m_ready;

  always_comb begin
    acc_ins = acc;
    acc_ins[idx*QB +: QB] = q;
  end

  always_comb begin
    state_nxt   = state;
    frame_done  = 1'b0;
    frame_short = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          if (idx == LAST_IDX) begin
            frame_done = 1'b1;
            if (!s_last) state_nxt = DISCARD;
          end else if (s_last) begin
            frame_short = 1'b1;
          end
        end
      end
      DISCARD: begin
        if (accept && s_last) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      idx      <= '0;
      acc      <= '0;
      acc_full <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      len_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      len_err <= frame_short || (frame_done && !s_last);

      if (m_valid && m_ready) m_valid <= 1'b0;

      // A parked frame moves out as soon as the output frees; a handshake in
      // the same cycle lets it replace the departing frame with no gap.
      if (acc_full && out_free) begin
        m_data   <= acc;
        m_valid  <= 1'b1;
        acc_full <= 1'b0;
      end

      if (state == FILL && accept) begin
        acc <= acc_ins;
        if (frame_done) begin
          idx <= '0;
          if (out_free) begin
            m_data  <= acc_ins;
            m_valid <= 1'b1;
          end else begin
            acc_full <= 1'b1;
          end
        end else if (frame_short) begin
          idx <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer0_input_packer.sv
// Scoreboard bench for layer0_input_packer: stimulus pushes expected packed
// frames into a queue; a negedge monitor pops and compares on every output
// handshake and checks that stalled outputs hold still.
module tb_layer0_input_packer;
  import luna_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     s_valid;
  logic                     s_ready;
  logic signed [FEAT_W-1:0] s_data;
  logic                     s_last;
  logic                     m_valid;
  logic                     m_ready;
  logic [OUT_W-1:0]         m_data;
  logic                     len_err;

  always #5 clk = ~clk;

  layer0_input_packer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .len_err (len_err)
  );

  int total = 0;
  int bad   = 0;
  logic [OUT_W-1:0] expq[$];
  int len_err_seen = 0;
  int len_err_exp  = 0;
  logic stall = 1'b0;
  logic [OUT_W-1:0] hold_d = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stimulus patterns: 0 ramp i*256, 1 eight-entry edge table, 2 negative ramp, 3 +max
  function automatic logic [15:0] pat_val(input int p, input int i);
    case (p)
      0: return 16'(i * 256);
      1: case (i % 8)
           0: return 16'h7FFF;
           1: return 16'h8000;
           2: return 16'h0000;
           3: return 16'h00FF;
           4: return 16'hFF00;
           5: return 16'hFEFF;
           6: return 16'h0100;
           default: return 16'h0200;
         endcase
      2: return 16'(-(i * 256));
      default: return 16'h7FFF;
    endcase
  endfunction

  // Hand-computed codes for the patterns above.
  function automatic logic [1:0] pat_code(input int p, input int i);
    case (p)
      0: return (i == 0) ? 2'd2 : 2'd3;
      1: case (i % 8)
           0: return 2'd3;
           1: return 2'd0;
           2: return 2'd2;
           3: return 2'd2;
           4: return 2'd1;
           5: return 2'd0;
           6: return 2'd3;
           default: return 2'd3;
         endcase
      2: return (i == 0) ? 2'd2 : ((i == 1) ? 2'd1 : 2'd0);
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [OUT_W-1:0] frame_exp(input int p);
    logic [OUT_W-1:0] f;
    f = '0;
    for (int i = 0; i < NUM_FEAT; i++) f[i*QB +: QB] = pat_code(p, i);
    return f;
  endfunction

  task automatic send_beat(input logic [15:0] d, input logic last);
    logic rdy;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
    end
    check("send_timeout_s_ready", s_ready, 1'b1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int p, input int n, input int last_at, input int tail_p);
    for (int i = 0; i < n; i++)
      send_beat((i < NUM_FEAT) ? pat_val(p, i) : pat_val(tail_p, i), i == last_at);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200; n++) begin
      if (expq.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_queue_empty", expq.size(), 0);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_m_valid", m_valid, 1'b1);
        check("hold_m_data", m_data, hold_d);
      end
      if (len_err) len_err_seen++;
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got %h expected none", m_data);
        end else begin
          check("frame_data", m_data, expq.pop_front());
        end
      end
      stall  = m_valid && !m_ready;
      hold_d = m_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_data", m_data, '0);
    check("rst_len_err", len_err, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ramp frame; m_valid must be up right after the last beat's edge.
    expq.push_back(frame_exp(0));
    send_frame(0, 32, 31, 0);
    check("latency_m_valid", m_valid, 1'b1);
    wait_drain();

    // Saturation / edge table
    expq.push_back(frame_exp(1));
    send_frame(1, 32, 31, 0);
    wait_drain();

    // Backpressure over two frames
    m_ready = 1'b0;
    expq.push_back(frame_exp(1));
    expq.push_back(frame_exp(2));
    send_frame(1, 32, 31, 0);
    send_frame(2, 32, 31, 0);
    check("bp_s_ready_low", s_ready, 1'b0);
    check("bp_m_valid_high", m_valid, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    check("bp_s_ready_still_low", s_ready, 1'b0);
    m_ready = 1'b1;
    wait_drain();
    check("bp_s_ready_back", s_ready, 1'b1);

    // Short frame dropped, then a clean frame
    send_frame(0, 11, 10, 0);
    len_err_exp++;
    repeat (3) @(posedge clk);
    #1;
    check("short_no_m_valid", m_valid, 1'b0);
    check("short_len_err_seen", len_err_seen, len_err_exp);
    expq.push_back(frame_exp(1));
    send_frame(1, 32, 31, 0);
    wait_drain();

    // Long frame: first 32 committed, tail dropped, next frame clean
    expq.push_back(frame_exp(2));
    send_frame(2, 40, 39, 3);
    len_err_exp++;
    expq.push_back(frame_exp(0));
    send_frame(0, 32, 31, 0);
    wait_drain();

    // Reset mid-frame while a stalled frame is on the output
    m_ready = 1'b0;
    expq.push_back(frame_exp(1));
    send_frame(1, 32, 31, 0);
    for (int i = 0; i < 17; i++) send_beat(pat_val(0, i), 1'b0);
    check("pre_reset_m_valid", m_valid, 1'b1);
    rst_n = 1'b0;
    expq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_reset_m_valid", m_valid, 1'b0);
    check("post_reset_s_ready", s_ready, 1'b1);
    check("post_reset_m_data", m_data, '0);
    m_ready = 1'b1;
    expq.push_back(frame_exp(2));
    send_frame(2, 32, 31, 0);
    wait_drain();

    repeat (3) @(posedge clk);
    #1;
    check("len_err_count", len_err_seen, len_err_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
